if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage: owns the fetch PC and feeds ID from an N-entry instruction queue.
//  Decouples prefetch-buffer wait states from ID stalls.
//  Takes PC redirects from ALU (branch) and MEM (load-to-PC), MEM having priority.
//  Sits between the instruction prefetch buffer and the ID stage.
// PARAMETERS
//  ADDR_WIDTH    32           address/PC width
//  INSTR_WIDTH   32           instruction word width
//  QUEUE_DEPTH   4            queue entries; power of two, >=2
//  PTR_WIDTH     2            log2(QUEUE_DEPTH)
//  RESET_VECTOR  32'h0        PC loaded at reset
// PORTS
//  clock                        in   1            single clock, rising edge
//  reset                        in   1            synchronous, active-high
//  out_InstructionAddress       out  ADDR_WIDTH   fetch address to prefetch buffer, always word aligned ({PC[A-1:2],2'b00})
//  out_FetchRequest             out  1            fetch attempted this cycle
//  in_Instruction               in   INSTR_WIDTH  fetched word, valid when request && !wait
//  in_InstructionWait           in   1            prefetch buffer not ready
//  in_ChangePC / in_NewPC       in   1 / ADDR_WIDTH   ALU redirect
//  in_MEMChangePC / in_MEMNewPC in   1 / ADDR_WIDTH   MEM redirect
//  in_ThumbState                in   1            1: 16-bit instructions
//  in_IDCanGo                   in   1            ID consumes head this cycle
//  out_Instruction              out  INSTR_WIDTH  queue head, zero when empty
//  out_ValidInstruction         out  1            queue non-empty
//  out_AddressGoWithInstruction out  ADDR_WIDTH   PC of head instruction, zero when empty
//  out_NextInstructionAddress   out  ADDR_WIDTH   current fetch PC
//  out_QueueCount               out  PTR_WIDTH+1  occupied entries
// BEHAVIOUR
//  Reset (sync, high):
//   - PC=RESET_VECTOR; queue empty; count=0.
//   - out_ValidInstruction=0; out_Instruction=0; out_AddressGoWithInstruction=0.
//  Fetch:
//   - out_FetchRequest = (count<QUEUE_DEPTH) && !redirect; registered count only, no path from in_IDCanGo.
//   - Accept = request && !in_InstructionWait.
//   - On accept: enqueue {in_Instruction, PC}; PC += 2 if in_ThumbState, else 4.
//   - Wait or full: PC holds.
//  Dequeue:
//   - Head pops when in_IDCanGo && out_ValidInstruction.
//   - Simultaneous enqueue+dequeue: count unchanged. Never at full, since no request is issued when full.
//  Latency: accepted fetch visible at out_Instruction the next cycle when the queue was empty.
//  Redirect:
//   - in_MEMChangePC wins over in_ChangePC.
//   - Effect: queue flushed (count=0, ptrs=0), PC={NewPC[A-1:1],1'b0}, no enqueue, no dequeue that cycle.
//   - First fetch from the new PC happens the following cycle.
//  Pointers: wrap modulo QUEUE_DEPTH; count is PTR_WIDTH+1 bits, so full (==DEPTH) is distinct from empty.
//  Thumb switch mid-stream: increment follows in_ThumbState sampled at the accept cycle.
//  Reset overrides redirect, fetch and dequeue in the same cycle.
// CONFIGURATION
//  IF_THUMB_HALFWORD_EN defined:
//   - In thumb state, enqueued data = {16'b0, PC[1] ? word[31:16] : word[15:0]}.
//  Not defined:
//   - Full fetched word is enqueued unchanged; ID selects the halfword using out_AddressGoWithInstruction[1].
// TESTING
//  1. Reset, RESET_VECTOR=0, wait=0, IDCanGo=1 -> out_Instruction sequence addr 0,4,8; count stays 1; PC steps by 4.
//  2. IDCanGo=0 for 6 cycles, wait=0:
//     - count reaches 4 and out_FetchRequest drops; PC=0x10.
//     - IDCanGo=1 then drains 0,4,8,C in order.
//  3. Queue holds 3, MEM redirect to 0x203 with simultaneous ALU redirect to 0x400:
//     - next cycle count=0, valid=0, PC=0x202.
//     - Then fetch address 0x200.
//  4. Thumb=1 from PC=0x100 with word 0xAAAA_BBBB:
//     - With IF_THUMB_HALFWORD_EN: heads 0x0000BBBB @0x100, 0x0000AAAA @0x102, both from fetch address 0x100.
//     - Without the macro: head is 0xAAAABBBB twice.
//  5. wait=1 for 3 cycles with queue empty -> valid=0, PC held, request held; wait=0 -> one entry next cycle.
//  6. Assert reset while queue full and redirect active -> next cycle PC=RESET_VECTOR, count=0, all outputs zero.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with an N-entry instruction queue.
// Owns the fetch PC, issues word-aligned fetches to the prefetch buffer and
// buffers {instruction, PC} pairs so that prefetch wait states and ID stalls
// are decoupled. MEM redirects take priority over ALU redirects.
// Optional feature macro: IF_THUMB_HALFWORD_EN (in thumb state, enqueue the
// selected halfword zero-extended instead of the full fetched word).
module if_fetch_queue #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INSTR_WIDTH  = 32,
  parameter int QUEUE_DEPTH  = 4,
  parameter int PTR_WIDTH    = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  out_InstructionAddress,
  output logic                   out_FetchRequest,
  input  logic [INSTR_WIDTH-1:0] in_Instruction,
  input  logic                   in_InstructionWait,
  input  logic                   in_ChangePC,
  input  logic [ADDR_WIDTH-1:0]  in_NewPC,
  input  logic                   in_MEMChangePC,
  input  logic [ADDR_WIDTH-1:0]  in_MEMNewPC,
  input  logic                   in_ThumbState,
  input  logic                   in_IDCanGo,
  output logic [INSTR_WIDTH-1:0] out_Instruction,
  output logic                   out_ValidInstruction,
  output logic [ADDR_WIDTH-1:0]  out_AddressGoWithInstruction,
  output logic [ADDR_WIDTH-1:0]  out_NextInstructionAddress,
  output logic [PTR_WIDTH:0]     out_QueueCount
);

  localparam logic [PTR_WIDTH:0] DEPTH_COUNT = (PTR_WIDTH+1)'(QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0]  pc;
  logic [PTR_WIDTH-1:0]   wrPtr;
  logic [PTR_WIDTH-1:0]   rdPtr;
  logic [PTR_WIDTH:0]     count;
  logic [INSTR_WIDTH-1:0] instrQueue [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  addrQueue  [QUEUE_DEPTH];

  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirectPc;
  logic                   accept;
  logic                   dequeue;
  logic [INSTR_WIDTH-1:0] enqueueData;
  logic [ADDR_WIDTH-1:0]  pcStep;

  // Redirect selection, fetch handshake and dequeue qualification.
  always_comb begin
    redirect   = in_MEMChangePC || in_ChangePC;
    redirectPc = in_MEMChangePC ? in_MEMNewPC : in_NewPC;
    // Request depends only on registered count, never on in_IDCanGo.
    out_FetchRequest = (count < DEPTH_COUNT) && !redirect;
    accept  = out_FetchRequest && !in_InstructionWait;
    dequeue = in_IDCanGo && (count != '0) && !redirect;
    pcStep  = in_ThumbState ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
  end

  // Data written into the queue on an accepted fetch.
  always_comb begin
`ifdef IF_THUMB_HALFWORD_EN
    if (in_ThumbState)
      enqueueData = {{(INSTR_WIDTH-16){1'b0}},
                     (pc[1] ? in_Instruction[31:16] : in_Instruction[15:0])};
    else
      enqueueData = in_Instruction;
`else
    enqueueData = in_Instruction;
`endif
  end

  // PC, pointers and occupancy; reset beats redirect beats fetch/dequeue.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_VECTOR;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (redirect) begin
      pc    <= {redirectPc[ADDR_WIDTH-1:1], 1'b0};
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        pc    <= pc + pcStep;
        wrPtr <= wrPtr + 1'b1;
      end
      if (dequeue)
        rdPtr <= rdPtr + 1'b1;
      if (accept && !dequeue)
        count <= count + 1'b1;
      else if (!accept && dequeue)
        count <= count - 1'b1;
    end
  end

  // Queue storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clock) begin
    if (!reset && !redirect && accept) begin
      instrQueue[wrPtr] <= enqueueData;
      addrQueue[wrPtr]  <= pc;
    end
  end

  // Output view of PC and queue head, zeroed while empty.
  always_comb begin
    out_InstructionAddress       = {pc[ADDR_WIDTH-1:2], 2'b00};
    out_NextInstructionAddress   = pc;
    out_QueueCount               = count;
    out_ValidInstruction         = (count != '0);
    out_Instruction              = out_ValidInstruction ? instrQueue[rdPtr] : '0;
    out_AddressGoWithInstruction = out_ValidInstruction ? addrQueue[rdPtr]  : '0;
  end

endmodule
